keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000, SHALL be the clock cycles each column is driven before its rows are sampled (one "tick").
REQ-002 Parameter DEBOUNCE_CNT, default 20, SHALL be the consecutive agreeing ticks needed to accept a press or a release.
REQ-003 clock  input  1  single system clock; all state SHALL change on its rising edge except under reset.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rows  input  4  keypad row lines, active-low (pulled up externally); asynchronous to clock.
REQ-006 columns  output  4  column drive, active-low one-hot; exactly one bit low at all times.
REQ-007 value  output  5  key event code {1'b1, col[1:0], row[1:0]}; 5'b00000 when no event.

Function
REQ-008 rows SHALL pass through a 2-flop synchronizer before any use; synchronizer resets to 4'b1111.
REQ-009 Tick counter SHALL count 0..SCAN_DIV-1 and wrap; a tick occurs on the cycle it equals SCAN_DIV-1; the synchronized rows are sampled only on ticks.
REQ-010 columns SHALL equal ~(4'b0001 << col_idx); col_idx advances 0->1->2->3->0 only as stated below.
REQ-011 "Single" sample: exactly one synchronized row bit low; zero or two-plus low bits are "invalid".
REQ-012 FSM states: SCAN, CONFIRM, HELD.
REQ-013 SCAN, tick, sample single: latch col=col_idx and row index; press count=1; go CONFIRM; col_idx does not advance.
REQ-014 SCAN, tick, sample not single: col_idx advances; stay SCAN.
REQ-015 CONFIRM, tick, same single row low: press count increments; on reaching DEBOUNCE_CNT, emit event and go HELD.
REQ-016 CONFIRM, tick, any other sample (other row, no row, multiple rows): discard latch, no event, advance col_idx, go SCAN.
REQ-017 HELD: column stays fixed; on each tick with the latched row high, release count increments; a tick with the latched row low clears release count to 0.
REQ-018 HELD: on release count reaching DEBOUNCE_CNT, advance col_idx and go SCAN; release count clears.
REQ-019 An event SHALL drive value={1,col,row} for exactly one clock cycle, registered, in the cycle after the accepting tick; value=5'b00000 in all other cycles.
REQ-020 A held key SHALL produce exactly one event (no auto-repeat); a new event for any key requires the release sequence of REQ-018 first.
REQ-021 Other keys pressed while in HELD SHALL be ignored.
REQ-022 Code map: col0 rows0-3 = 1,4,7,0; col1 = 2,5,8,(unused); col2 = 3,6,9,(unused); col3 = A,B,C,D.
REQ-023 Press latency SHALL be at most 2 + 5*SCAN_DIV + DEBOUNCE_CNT*SCAN_DIV + 1 cycles from the stable-low row.
REQ-024 Counters SHALL be sized to hold SCAN_DIV-1 and DEBOUNCE_CNT without wrap.

Reset
REQ-025 On reset assertion, immediately: state=SCAN, col_idx=0, columns=4'b1110, value=5'b00000, all counters 0, synchronizer 4'b1111.
REQ-026 Reset asserted in CONFIRM or HELD SHALL abort the operation with no event emitted, either during reset or after release.
REQ-027 After reset deassertion, the first tick SHALL occur SCAN_DIV cycles later, sampling column 0.

Verification (bench uses SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-028 Reset held, rows=1111 -> columns=1110, value=00000; after release, columns rotate 1110,1101,1011,0111 every 4 cycles.
REQ-029 Press '5' (rows[1] low whenever columns[1] low), held 100 cycles -> exactly one cycle value=10101, columns frozen at 1101 while held.
REQ-030 Bounce: rows[1] low for 2 ticks on col1, then high -> no event; scanning resumes at col2.
REQ-031 rows[0] and rows[2] both low on col0 -> no event; columns keep rotating.
REQ-032 Press 'D' (col3, row3), release 3+ ticks, press again -> two separate single-cycle events value=11111.
REQ-033 Reset pulsed while in CONFIRM for '1' -> value stays 00000 throughout; columns=1110 after reset.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces a single
// pressed key and emits a one-cycle {1, col, row} event code per accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] columns,
  output logic [4:0] value
);

  localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT + 1) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2
  } state_t;

  // True when exactly one active-low row line is asserted.
  function automatic logic is_single(input logic [3:0] r);
    int zeros;
    zeros = 0;
    for (int i = 0; i < 4; i++) begin
      if (r[i] == 1'b0) begin
        zeros = zeros + 1;
      end else begin
        zeros = zeros;
      end
    end
    return (zeros == 1);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] r);
    logic [1:0] idx;
    case (r)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  logic [3:0]        sync1_r, sync2_r;
  logic [TICK_W-1:0] tick_cnt_r;
  logic              tick_s;

  state_t            state_r, state_next_s;
  logic [1:0]        col_idx_r, col_idx_next_s;
  logic [1:0]        latch_col_r, latch_col_next_s;
  logic [1:0]        latch_row_r, latch_row_next_s;
  logic [DEB_W-1:0]  press_cnt_r, press_cnt_next_s;
  logic [DEB_W-1:0]  rel_cnt_r, rel_cnt_next_s;
  logic [4:0]        value_r, value_next_s;
  logic [3:0]        columns_r;
  logic              single_s;
  logic [1:0]        row_idx_s;

  assign tick_s    = (tick_cnt_r == TICK_LAST);
  assign single_s  = is_single(sync2_r);
  assign row_idx_s = low_index(sync2_r);
  assign columns   = columns_r;
  assign value     = value_r;

  // Row synchronizer and scan-rate tick divider.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r    <= 4'b1111;
      sync2_r    <= 4'b1111;
      tick_cnt_r <= '0;
    end else begin
      sync1_r    <= rows;
      sync2_r    <= sync1_r;
      tick_cnt_r <= tick_s ? '0 : tick_cnt_r + TICK_W'(1);
    end
  end

  // Scan / debounce state register; columns track the next column index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= SCAN;
      col_idx_r   <= 2'd0;
      latch_col_r <= 2'd0;
      latch_row_r <= 2'd0;
      press_cnt_r <= '0;
      rel_cnt_r   <= '0;
      value_r     <= 5'b00000;
      columns_r   <= 4'b1110;
    end else begin
      state_r     <= state_next_s;
      col_idx_r   <= col_idx_next_s;
      latch_col_r <= latch_col_next_s;
      latch_row_r <= latch_row_next_s;
      press_cnt_r <= press_cnt_next_s;
      rel_cnt_r   <= rel_cnt_next_s;
      value_r     <= value_next_s;
      columns_r   <= ~(4'b0001 << col_idx_next_s);
    end
  end

  // Next-state logic; everything only moves on a tick, value pulses for one cycle.
  always_comb begin
    state_next_s     = state_r;
    col_idx_next_s   = col_idx_r;
    latch_col_next_s = latch_col_r;
    latch_row_next_s = latch_row_r;
    press_cnt_next_s = press_cnt_r;
    rel_cnt_next_s   = rel_cnt_r;
    value_next_s     = 5'b00000;
    if (tick_s) begin
      case (state_r)
        SCAN: begin
          if (single_s) begin
            latch_col_next_s = col_idx_r;
            latch_row_next_s = row_idx_s;
            press_cnt_next_s = DEB_W'(1);
            state_next_s     = CONFIRM;
          end else begin
            col_idx_next_s = col_idx_r + 2'd1;
          end
        end
        CONFIRM: begin
          if (single_s && (row_idx_s == latch_row_r)) begin
            if (press_cnt_r >= DEB_LAST) begin
              value_next_s     = {1'b1, latch_col_r, latch_row_r};
              press_cnt_next_s = '0;
              rel_cnt_next_s   = '0;
              state_next_s     = HELD;
            end else begin
              press_cnt_next_s = press_cnt_r + DEB_W'(1);
            end
          end else begin
            press_cnt_next_s = '0;
            col_idx_next_s   = col_idx_r + 2'd1;
            state_next_s     = SCAN;
          end
        end
        HELD: begin
          // Only the latched row matters here; other keys are ignored.
          if (sync2_r[latch_row_r]) begin
            if (rel_cnt_r >= DEB_LAST) begin
              rel_cnt_next_s = '0;
              col_idx_next_s = col_idx_r + 2'd1;
              state_next_s   = SCAN;
            end else begin
              rel_cnt_next_s = rel_cnt_r + DEB_W'(1);
            end
          end else begin
            rel_cnt_next_s = '0;
          end
        end
        default: begin
          state_next_s     = SCAN;
          col_idx_next_s   = 2'd0;
          press_cnt_next_s = '0;
          rel_cnt_next_s   = '0;
        end
      endcase
    end else begin
      value_next_s = 5'b00000;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3 and a
// behavioural keypad matrix that pulls rows low for pressed keys in the driven column.
module tb_keypad_scanner;

  logic       clock;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] columns;
  logic [4:0] value;

  logic [3:0] key_mask [4];
  int         errors;
  int         checks;
  int         event_count;
  logic [4:0] last_value;
  int         base;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clock   (clock),
    .reset   (reset),
    .rows    (rows),
    .columns (columns),
    .value   (value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Keypad matrix: a pressed key shorts its row to its column when that column is low.
  always_comb begin
    rows = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      if (columns[c] == 1'b0) rows = rows & ~key_mask[c];
    end
  end

  // Event monitor: one count per clock cycle with a nonzero code.
  always @(negedge clock) begin
    if (value !== 5'b00000) begin
      event_count <= event_count + 1;
      last_value  <= value;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_keys();
    for (int c = 0; c < 4; c++) key_mask[c] = 4'b0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_cols [4];
    exp_cols[0] = 4'b1101; exp_cols[1] = 4'b1011; exp_cols[2] = 4'b0111; exp_cols[3] = 4'b1110;
    clear_keys();
    reset = 1'b1;
    wait_cycles(3);
    checks++;
    if (columns !== 4'b1110) begin errors++; $display("FAIL reset_columns got=%b exp=1110", columns); end
    checks++;
    if (value !== 5'b00000) begin errors++; $display("FAIL reset_value got=%b exp=00000", value); end
    reset = 1'b0;
    wait_cycles(3);
    checks++;
    if (columns !== 4'b1110) begin errors++; $display("FAIL first_tick_early got=%b exp=1110", columns); end
    wait_cycles(1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (columns !== exp_cols[i]) begin
        errors++; $display("FAIL rotate_%0d got=%b exp=%b", i, columns, exp_cols[i]);
      end
      wait_cycles(4);
    end
  endtask

  task automatic test_press_5();
    clear_keys();
    do_reset();
    base = event_count;
    key_mask[1] = 4'b0010;
    wait_cycles(15);
    checks++;
    if (value !== 5'b00000) begin errors++; $display("FAIL press5_early got=%b exp=00000", value); end
    wait_cycles(1);
    checks++;
    if (value !== 5'b10101) begin errors++; $display("FAIL press5_value got=%b exp=10101", value); end
    wait_cycles(1);
    checks++;
    if (value !== 5'b00000) begin errors++; $display("FAIL press5_pulse_width got=%b exp=00000", value); end
    wait_cycles(83);
    checks++;
    if (event_count - base !== 1) begin errors++; $display("FAIL press5_count got=%0d exp=1", event_count - base); end
    checks++;
    if (last_value !== 5'b10101) begin errors++; $display("FAIL press5_last got=%b exp=10101", last_value); end
    checks++;
    if (columns !== 4'b1101) begin errors++; $display("FAIL press5_frozen got=%b exp=1101", columns); end
    key_mask[3] = 4'b1000;
    wait_cycles(20);
    checks++;
    if (columns !== 4'b1101 || event_count - base !== 1) begin
      errors++; $display("FAIL held_ignore_other cols=%b events=%0d exp 1101/1", columns, event_count - base);
    end
    clear_keys();
  endtask

  task automatic test_bounce();
    clear_keys();
    do_reset();
    base = event_count;
    key_mask[1] = 4'b0010;
    wait_cycles(12);
    key_mask[1] = 4'b0000;
    wait_cycles(4);
    checks++;
    if (columns !== 4'b1011) begin errors++; $display("FAIL bounce_resume got=%b exp=1011", columns); end
    wait_cycles(4);
    checks++;
    if (columns !== 4'b0111) begin errors++; $display("FAIL bounce_rotate got=%b exp=0111", columns); end
    wait_cycles(20);
    checks++;
    if (event_count - base !== 0) begin errors++; $display("FAIL bounce_no_event got=%0d exp=0", event_count - base); end
  endtask

  task automatic test_multi_row();
    clear_keys();
    do_reset();
    base = event_count;
    key_mask[0] = 4'b0101;
    wait_cycles(4);
    checks++;
    if (columns !== 4'b1101) begin errors++; $display("FAIL multi_advance got=%b exp=1101", columns); end
    wait_cycles(12);
    checks++;
    if (columns !== 4'b1110) begin errors++; $display("FAIL multi_wrap got=%b exp=1110", columns); end
    wait_cycles(4);
    checks++;
    if (columns !== 4'b1101) begin errors++; $display("FAIL multi_again got=%b exp=1101", columns); end
    checks++;
    if (event_count - base !== 0) begin errors++; $display("FAIL multi_no_event got=%0d exp=0", event_count - base); end
    clear_keys();
  endtask

  task automatic test_back_to_back();
    clear_keys();
    do_reset();
    base = event_count;
    key_mask[3] = 4'b1000;
    wait_cycles(40);
    checks++;
    if (event_count - base !== 1 || last_value !== 5'b11111) begin
      errors++; $display("FAIL d_first events=%0d last=%b exp 1/11111", event_count - base, last_value);
    end
    checks++;
    if (columns !== 4'b0111) begin errors++; $display("FAIL d_frozen got=%b exp=0111", columns); end
    wait_cycles(40);
    checks++;
    if (event_count - base !== 1) begin errors++; $display("FAIL d_no_repeat got=%0d exp=1", event_count - base); end
    key_mask[3] = 4'b0000;
    wait_cycles(20);
    checks++;
    if (event_count - base !== 1) begin errors++; $display("FAIL d_release got=%0d exp=1", event_count - base); end
    key_mask[3] = 4'b1000;
    wait_cycles(60);
    checks++;
    if (event_count - base !== 2 || last_value !== 5'b11111) begin
      errors++; $display("FAIL d_second events=%0d last=%b exp 2/11111", event_count - base, last_value);
    end
    clear_keys();
  endtask

  task automatic test_reset_abort();
    clear_keys();
    do_reset();
    base = event_count;
    key_mask[0] = 4'b0001;
    wait_cycles(6);
    reset = 1'b1;
    clear_keys();
    #1;
    checks++;
    if (columns !== 4'b1110 || value !== 5'b00000) begin
      errors++; $display("FAIL abort_immediate cols=%b value=%b exp 1110/00000", columns, value);
    end
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(1);
    checks++;
    if (columns !== 4'b1110) begin errors++; $display("FAIL abort_cols got=%b exp=1110", columns); end
    wait_cycles(40);
    checks++;
    if (event_count - base !== 0) begin errors++; $display("FAIL abort_no_event got=%0d exp=0", event_count - base); end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    event_count = 0;
    last_value  = 5'b00000;
    base        = 0;
    reset       = 1'b1;
    for (int c = 0; c < 4; c++) key_mask[c] = 4'b0000;
    test_reset();
    test_press_5();
    test_bounce();
    test_multi_row();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
